i2s_aud_tx: RTL and testbench
=============================

Name: i2s_aud_tx

Overview:
- Native memory interface (nmi) responder on the audio clock domain: the slave-side end of the CPU-to-audio nmi bridge.
- Replaces the tied-off slave ready/rdata, so audio-side transactions complete.
- Holds a small control/status register set and a stereo sample FIFO.
- Serializes FIFO samples onto a Philips-format I2S transmit link (SCK/WS/SD) and raises a FIFO-level interrupt.

Parameters:
- FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the FIFO level count.

Ports:
- clk_i  in  1  audio clock; single clock for the whole block.
- rst_n_i  in  1  asynchronous active-low reset.
- mem_valid_i  in  1  nmi request valid; held until mem_ready_o.
- mem_addr_i  in  32  byte address; only [4:2] decoded.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; 0 means read.
- mem_rdata_o  out  32  read data; valid while mem_ready_o=1.
- mem_ready_o  out  1  one-cycle completion pulse.
- i2s_sck_o  out  1  bit clock.
- i2s_ws_o  out  1  word select: 0 = left, 1 = right.
- i2s_sd_o  out  1  serial data, MSB first.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: mem_ready_o=0, mem_rdata_o=0, sck/ws/sd=0, irq_o=0.
  - Registers: CTRL=0, CLKDIV=3, THRESH=0, sticky flags=0.
  - FIFO emptied; slot=31; divcnt=0.
- nmi handshake:
  - If mem_valid_i=1 and mem_ready_o=0 in cycle N, the access executes in N and mem_ready_o=1 in N+1 for exactly one cycle.
  - mem_ready_o is registered; a held valid therefore completes at most every other cycle.
  - mem_rdata_o=0 when the access is a write.
  - Unmapped offsets: read 0, write ignored, still acknowledged.
- Register map (offset from mem_addr_i[4:2]):
  - 0x00 CTRL RW: [0] en, [1] mono, [2] irq_en; others read 0. Byte strobe wstrb[0] applies.
  - 0x04 CLKDIV RW [7:0]: SCK half-period = CLKDIV+1 clk cycles. Byte strobe wstrb[0] applies.
  - 0x08 TXDATA WO: any nonzero wstrb pushes the full word {L[31:16], R[15:0]}. Read returns 0.
  - 0x0C STATUS:
    - Read: [0] full, [1] empty, [2] ovf, [3] udf, [8+:LVL_W] level.
    - Write 1 to [2]/[3] clears the matching sticky flag; other bits are read-only.
  - 0x10 THRESH RW [LVL_W-1:0].
- FIFO rules:
  - Push while full with no same-cycle pop: data dropped, ovf<=1.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no ovf.
  - Pop while empty: underflow, frame transmits zeros, udf<=1. A same-cycle push is still stored (level becomes 1).
  - If a sticky flag sets and is W1C-cleared in the same cycle, the set wins.
- Interrupt: irq_o registered, = irq_en & (level <= THRESH).
- Serializer, en=0:
  - sck/ws/sd held 0, divcnt=0, slot=31.
  - FIFO contents retained.
  - Clearing en mid-frame aborts the current frame immediately; the partially sent word is discarded.
- Serializer, en=1:
  - divcnt counts 0..CLKDIV. At divcnt==CLKDIV, sck toggles and divcnt<=0.
  - A CLKDIV write takes effect at the next wrap; if divcnt > new CLKDIV, it wraps at 255→0.
- Falling event (sck 1→0):
  - slot<=slot+1 mod 32.
  - When the new slot=0: pop FIFO into a 32-bit shift register. Mono mode loads {L,L}; underflow loads 0.
  - sd_o<=frame bit (31-slot), MSB first.
  - ws_o<=1 for slot 15..30, 0 for slot 31 and 0..14. WS therefore leads data by one bit (Philips).
- Rising events only toggle sck. Data and WS are stable across the rising edge.
- First falling event after en rises occurs 2*(CLKDIV+1) cycles after en is sampled. Frame period = 64*(CLKDIV+1) cycles.

Decomposition:
- Package i2s_aud_pkg:
  - Register offset localparams (CTRL/CLKDIV/TXDATA/STATUS/THRESH).
  - CTRL and STATUS bit-index constants.
  - CLKDIV reset value 8'd3.
  - Frame width 32 and slot count 32.
- Sub-module i2s_aud_fifo: single-clock, FIFO_DEPTH x 32.
  - push/pop/full/empty/level outputs.
  - Implements the simultaneous push/pop rules above.
- The top holds the nmi decode, registers, IRQ and serializer.

Test Plan:
- Register access: write CLKDIV=0x01, CTRL=0x5, then read both → 0x01 and 0x5, each with mem_ready_o high exactly one cycle, one cycle after valid; read 0x1C → 0.
- Serial frame: CLKDIV=1, push 0xA5A5_3C3C, en=1 → sck period 4 clk; after slot-0 fall SD = 1,0,1,0,0,1,0,1,... on successive falls. WS rises at slot 15 (one bit before R MSB) and falls at slot 31.
- Overflow: push FIFO_DEPTH+1 words with en=0 → STATUS full=1, level=8, ovf=1; write STATUS 0x4 → ovf=0, full unchanged.
- Underflow/mono: en=1 with FIFO empty → SD all 0, udf=1. Then mono=1 and push 0x8001_FFFF → both halves send 0x8001.
- IRQ: THRESH=2, irq_en=1, push 3 words → irq_o=0; after one frame pops (level 2) → irq_o=1.
- Abort/reset: clear en at slot 10 → sck/ws/sd 0 next cycle and remaining FIFO words kept. Assert rst_n_i mid-frame → all outputs 0 asynchronously and level=0.

Source files
------------

// File: rtl/i2s_aud_pkg.sv
// Shared constants for the audio-side nmi responder and I2S transmitter:
// register offsets, bit positions and frame geometry.
package i2s_aud_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_CLKDIV = 3'd1;
    localparam logic [2:0] OFF_TXDATA = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_THRESH = 3'd4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;
    localparam int ST_LVL   = 8;

    localparam logic [7:0] CLKDIV_RST = 8'd3;

    localparam int FRAME_W  = 32;
    localparam int SLOT_CNT = 32;
    localparam int SLOT_W   = $clog2(SLOT_CNT);

    // Bit 0 is en, bit 1 is mono, bit 2 is irq_en.
    typedef struct packed {
        logic irq_en;
        logic mono;
        logic en;
    } ctrl_t;

    // WS is high for the right channel; it switches one slot before the MSB.
    function automatic logic ws_for_slot(input logic [SLOT_W-1:0] slot);
        return (slot >= SLOT_W'(15)) && (slot <= SLOT_W'(30));
    endfunction

endpackage

// File: rtl/i2s_aud_fifo.sv
// Single-clock sample FIFO with first-word-fall-through read; a push into a
// full FIFO succeeds only when a pop happens in the same cycle.
module i2s_aud_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [31:0]      wdata_i,
    input  logic             pop_i,
    output logic [31:0]      rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || pop_i);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/i2s_aud_tx.sv
// Audio-domain nmi responder: control/status registers, stereo sample FIFO,
// Philips I2S serializer and FIFO-level interrupt.
module i2s_aud_tx
    import i2s_aud_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        i2s_sck_o,
    output logic        i2s_ws_o,
    output logic        i2s_sd_o,
    output logic        irq_o
);

    logic [2:0]         off;
    logic               access, wr, rd, push, pop, clr;
    logic               ovf_evt, udf_evt;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [31:0]        fifo_rdata, status_w;
    logic [FRAME_W-1:0] frame_w;

    ctrl_t              ctrl_q, ctrl_d;
    logic [7:0]         clkdiv_q, clkdiv_d, divcnt_q, divcnt_d;
    logic [LVL_W-1:0]   thresh_q, thresh_d;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    logic               ready_q, ready_d, irq_q, irq_d;
    logic               sck_q, sck_d, ws_q, ws_d, sd_q, sd_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[31:5], mem_addr_i[1:0]};

    assign off = mem_addr_i[4:2];

    i2s_aud_fifo #(.DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .wdata_i (mem_wdata_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        access  = mem_valid_i && !ready_q;
        wr      = access && (mem_wstrb_i != 4'b0000);
        rd      = access && (mem_wstrb_i == 4'b0000);
        push    = wr && (off == OFF_TXDATA);
        clr     = wr && (off == OFF_STATUS);
        ready_d = access;

        status_w                  = '0;
        status_w[ST_FULL]         = fifo_full;
        status_w[ST_EMPTY]        = fifo_empty;
        status_w[ST_OVF]          = ovf_q;
        status_w[ST_UDF]          = udf_q;
        status_w[ST_LVL +: LVL_W] = fifo_level;

        rdata_d = '0;
        if (rd) begin
            case (off)
                OFF_CTRL:   rdata_d = {29'b0, ctrl_q};
                OFF_CLKDIV: rdata_d = {24'b0, clkdiv_q};
                OFF_STATUS: rdata_d = status_w;
                OFF_THRESH: rdata_d[LVL_W-1:0] = thresh_q;
                default:    rdata_d = '0;
            endcase
        end

        ctrl_d   = ctrl_q;
        clkdiv_d = clkdiv_q;
        thresh_d = thresh_q;
        if (wr && (off == OFF_CTRL) && mem_wstrb_i[0]) begin
            ctrl_d = ctrl_t'(mem_wdata_i[2:0]);
        end
        if (wr && (off == OFF_CLKDIV) && mem_wstrb_i[0]) begin
            clkdiv_d = mem_wdata_i[7:0];
        end
        if (wr && (off == OFF_THRESH)) begin
            thresh_d = mem_wdata_i[LVL_W-1:0];
        end

        // A flag raised in the same cycle as its W1C clear stays set.
        ovf_evt = push && fifo_full && !pop;
        udf_evt = pop && fifo_empty;
        ovf_d   = ovf_evt || (ovf_q && !(clr && mem_wdata_i[ST_OVF]));
        udf_d   = udf_evt || (udf_q && !(clr && mem_wdata_i[ST_UDF]));

        irq_d = ctrl_q.irq_en && (fifo_level <= thresh_q);
    end

    always_comb begin
        sck_d    = sck_q;
        ws_d     = ws_q;
        sd_d     = sd_q;
        divcnt_d = divcnt_q;
        slot_d   = slot_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        frame_w  = fifo_empty ? '0
                 : (ctrl_q.mono ? {2{fifo_rdata[31:16]}} : fifo_rdata);

        if (!ctrl_q.en) begin
            sck_d    = 1'b0;
            ws_d     = 1'b0;
            sd_d     = 1'b0;
            divcnt_d = '0;
            slot_d   = SLOT_W'(SLOT_CNT - 1);
        end else if (divcnt_q != clkdiv_q) begin
            // Free-running 8-bit count: a shrunken CLKDIV wraps through 255.
            divcnt_d = divcnt_q + 8'd1;
        end else begin
            divcnt_d = '0;
            sck_d    = !sck_q;
            if (sck_q) begin
                slot_d = slot_q + SLOT_W'(1);
                ws_d   = ws_for_slot(slot_d);
                if (slot_d == '0) begin
                    pop     = 1'b1;
                    sd_d    = frame_w[FRAME_W-1];
                    shift_d = {frame_w[FRAME_W-2:0], 1'b0};
                end else begin
                    sd_d    = shift_q[FRAME_W-1];
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            clkdiv_q <= CLKDIV_RST;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            divcnt_q <= '0;
            slot_q   <= SLOT_W'(SLOT_CNT - 1);
            shift_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            clkdiv_q <= clkdiv_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            sck_q    <= sck_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            divcnt_q <= divcnt_d;
            slot_q   <= slot_d;
            shift_q  <= shift_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign i2s_sck_o   = sck_q;
    assign i2s_ws_o    = ws_q;
    assign i2s_sd_o    = sd_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_i2s_aud_tx.sv
// Directed bench for i2s_aud_tx: register access, serial frames, FIFO
// overflow/underflow, mono, IRQ threshold, abort and asynchronous reset.
module tb_i2s_aud_tx;

    logic        clk_i       = 1'b0;
    logic        rst_n_i     = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_addr_i  = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [3:0]  mem_wstrb_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ready_o;
    logic        i2s_sck_o;
    logic        i2s_ws_o;
    logic        i2s_sd_o;
    logic        irq_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rd_q [$];
    logic [31:0] sd_q [$];

    localparam logic [31:0] WS_FULL = 32'h7FFF_8000;

    always #5 clk_i = ~clk_i;

    i2s_aud_tx dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .mem_valid_i (mem_valid_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wstrb_i (mem_wstrb_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_ready_o (mem_ready_o),
        .i2s_sck_o   (i2s_sck_o),
        .i2s_ws_o    (i2s_ws_o),
        .i2s_sd_o    (i2s_sd_o),
        .irq_o       (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd);
        @(negedge clk_i);
        check("ready_idle", {31'b0, mem_ready_o}, 32'd0);
        mem_valid_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_wstrb_i = st;
        @(negedge clk_i);
        check("ready_ack", {31'b0, mem_ready_o}, 32'd1);
        rd          = mem_rdata_o;
        mem_valid_i = 1'b0;
        mem_wstrb_i = 4'b0000;
        @(negedge clk_i);
        check("ready_pulse", {31'b0, mem_ready_o}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        bus(addr, data, 4'hF, r);
        check("wr_rdata", r, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic [31:0] e;
        rd_q.push_back(exp);
        bus(addr, 32'd0, 4'b0000, r);
        e = rd_q.pop_front();
        check(tag, r, e);
    endtask

    // Samples SD/WS after each SCK falling edge; first sample lands in bit 0 of ws.
    task automatic capture(input int nbits, output logic [31:0] sd_bits, output logic [31:0] ws_bits);
        logic prev;
        int   got;
        int   budget;
        sd_bits = '0;
        ws_bits = '0;
        prev    = i2s_sck_o;
        got     = 0;
        budget  = nbits * 8 + 32;
        while (got < nbits && budget > 0) begin
            @(negedge clk_i);
            budget--;
            if (prev && !i2s_sck_o) begin
                sd_bits      = {sd_bits[30:0], i2s_sd_o};
                ws_bits[got] = i2s_ws_o;
                got++;
            end
            prev = i2s_sck_o;
        end
        check("fall_budget", 32'(got), 32'(nbits));
    endtask

    task automatic frame_chk(input string tag);
        logic [31:0] s;
        logic [31:0] w;
        logic [31:0] e;
        capture(32, s, w);
        e = (sd_q.size() > 0) ? sd_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_sd"}, s, e);
        check({tag, "_ws"}, w, WS_FULL);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] w;
        logic [31:0] e;
        logic [31:0] word;

        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", {31'b0, mem_ready_o}, 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);
        check("rst_sck",   {31'b0, i2s_sck_o}, 32'd0);
        check("rst_ws",    {31'b0, i2s_ws_o}, 32'd0);
        check("rst_sd",    {31'b0, i2s_sd_o}, 32'd0);
        check("rst_irq",   {31'b0, irq_o}, 32'd0);
        rst_n_i = 1'b1;
        rd_chk("rst_ctrl",   32'h00, 32'd0);
        rd_chk("rst_clkdiv", 32'h04, 32'd3);
        rd_chk("rst_thresh", 32'h10, 32'd0);
        rd_chk("rst_status", 32'h0C, 32'h2);

        // Register access and unmapped offsets
        wr(32'h04, 32'h01);
        wr(32'h00, 32'h5);
        rd_chk("clkdiv", 32'h04, 32'h01);
        rd_chk("ctrl", 32'h00, 32'h5);
        rd_chk("unmapped", 32'h1C, 32'd0);
        wr(32'h1C, 32'hFFFF_FFFF);
        rd_chk("ctrl_kept", 32'h00, 32'h5);
        rd_chk("txdata_rd", 32'h08, 32'd0);
        wr(32'h00, 32'h0);
        wr(32'h0C, 32'hC);
        rd_chk("status_clr", 32'h0C, 32'h2);

        // Single stereo frame
        wr(32'h08, 32'hA5A5_3C3C);
        sd_q.push_back(32'hA5A5_3C3C);
        wr(32'h00, 32'h1);
        frame_chk("frame_a5");
        wr(32'h00, 32'h0);
        rd_chk("status_frame", 32'h0C, 32'h2);

        // Overflow with serializer idle
        for (int i = 0; i < 9; i++) begin
            word = 32'hC3A5_0F00 + 32'(i) * 32'h0101_0101;
            wr(32'h08, word);
            if (i < 8) sd_q.push_back(word);
        end
        rd_chk("ovf_status", 32'h0C, 32'h805);
        wr(32'h0C, 32'h4);
        rd_chk("ovf_clear", 32'h0C, 32'h801);

        // Drain five frames back to back
        wr(32'h00, 32'h1);
        for (int f = 0; f < 5; f++) frame_chk("frame_fifo");
        wr(32'h00, 32'h0);
        rd_chk("level3", 32'h0C, 32'h300);

        // IRQ threshold
        wr(32'h10, 32'd2);
        rd_chk("thresh", 32'h10, 32'd2);
        wr(32'h00, 32'h4);
        @(negedge clk_i);
        check("irq_lvl3", {31'b0, irq_o}, 32'd0);
        wr(32'h00, 32'h5);
        frame_chk("frame_irq");
        check("irq_lvl2", {31'b0, irq_o}, 32'd1);

        // Abort after slot 10
        capture(11, s, w);
        e = (sd_q.size() > 0) ? sd_q.pop_front() : 32'hDEAD_BEEF;
        check("abort_part", s, e >> 21);
        check("abort_ws", w, 32'd0);
        wr(32'h00, 32'h4);
        check("abort_sck", {31'b0, i2s_sck_o}, 32'd0);
        check("abort_ws0", {31'b0, i2s_ws_o}, 32'd0);
        check("abort_sd",  {31'b0, i2s_sd_o}, 32'd0);
        rd_chk("abort_level", 32'h0C, 32'h100);
        check("abort_irq", {31'b0, irq_o}, 32'd1);

        // Last word then underflow
        wr(32'h00, 32'h1);
        frame_chk("frame_last");
        capture(32, s, w);
        check("udf_sd", s, 32'd0);
        check("udf_ws", w, WS_FULL);
        wr(32'h00, 32'h0);
        rd_chk("udf_status", 32'h0C, 32'h00A);

        // Mono
        wr(32'h0C, 32'h8);
        wr(32'h00, 32'h2);
        wr(32'h08, 32'h8001_FFFF);
        sd_q.push_back(32'h8001_8001);
        wr(32'h00, 32'h3);
        frame_chk("frame_mono");
        wr(32'h00, 32'h0);
        rd_chk("mono_status", 32'h0C, 32'h2);

        // Asynchronous reset mid-frame
        wr(32'h08, 32'h1234_5678);
        wr(32'h08, 32'h9ABC_DEF0);
        wr(32'h00, 32'h1);
        capture(4, s, w);
        check("pre_rst_bits", s, 32'h1234_5678 >> 28);
        repeat (2) @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_sck",   {31'b0, i2s_sck_o}, 32'd0);
        check("arst_ws",    {31'b0, i2s_ws_o}, 32'd0);
        check("arst_sd",    {31'b0, i2s_sd_o}, 32'd0);
        check("arst_ready", {31'b0, mem_ready_o}, 32'd0);
        check("arst_rdata", mem_rdata_o, 32'd0);
        check("arst_irq",   {31'b0, irq_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        sd_q.delete();
        rd_chk("arst_status", 32'h0C, 32'h2);
        rd_chk("arst_ctrl", 32'h00, 32'd0);
        rd_chk("arst_clkdiv", 32'h04, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
